// File: rtl/i2s_pkg.sv
// Shared encodings for the I2S ratio controller: divider modes, FSM states, frame ratios.
// Latency: none (types, constants and one combinational helper).
// Backpressure: none; the bck/lrck stream cannot be stalled.
package i2s_pkg;

   typedef enum logic [1:0] {
      MODE_64FS  = 2'b00,
      MODE_128FS = 2'b01,
      MODE_256FS = 2'b10,
      MODE_NONE  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_UNLOCKED  = 2'b00,
      ST_ACQUIRE   = 2'b01,
      ST_MUTE_HOLD = 2'b10,
      ST_LOCKED    = 2'b11
   } state_e;

   localparam int unsigned RATIO_64  = 64;
   localparam int unsigned RATIO_128 = 128;
   localparam int unsigned RATIO_256 = 256;

   // Exact-match classification of a frame length; anything else has no divider mode.
   function automatic mode_e classify(input int unsigned len);
      mode_e m;
      case (len)
         RATIO_64:  m = MODE_64FS;
         RATIO_128: m = MODE_128FS;
         RATIO_256: m = MODE_256FS;
         default:   m = MODE_NONE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/i2s_ratio_controller_if.sv
// Status bundle between the ratio controller and the BCK divider / re-timer.
// Latency: wires only; all outputs are registered inside the controller.
// Backpressure: none; lrck is a free-running input, status is level/pulse.
interface i2s_ratio_controller_if #(
   parameter int CNT_W = 10
);
   logic             lrck;
   logic [1:0]       mode;
   logic             locked;
   logic             mute;
   logic             div_rst;
   logic [CNT_W-1:0] period;

   modport master (input lrck, output mode, locked, mute, div_rst, period);
   modport slave  (output lrck, input mode, locked, mute, div_rst, period);
endinterface

// File: rtl/i2s_period_meter.sv
// Measures bck cycles between lrck rising edges, classifies the ratio, flags a stalled lrck.
// Latency: meas_vld/meas_cls/timeout combinational in the rise cycle; period registered (+1).
// Backpressure: none; every rise is measured, the first after reset/timeout only primes.
module i2s_period_meter
   import i2s_pkg::*;
#(
   parameter int CNT_W   = 10,
   parameter int TIMEOUT = 511
) (
   input  logic             bck,
   input  logic             rst_n,
   input  logic             lrck,
   output logic [CNT_W-1:0] period,
   output logic             meas_vld,
   output mode_e            meas_cls,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   logic             lrck_d;
   logic             primed;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   // lrck is generated in the bck domain, so a single register is enough for edge detect.
   assign rise     = lrck & ~lrck_d;
   assign cnt_inc  = cnt + 1'b1;
   assign meas_vld = rise & primed;
   assign meas_cls = classify({{(32-CNT_W){1'b0}}, cnt_inc});
   // A rise in the same cycle as the saturated count still counts as a frame.
   assign timeout  = ~rise & (cnt == CNT_MAX);

   // Edge history, frame-length counter with saturation, priming and last period.
   always_ff @(posedge bck or negedge rst_n) begin
      if (!rst_n) begin
         lrck_d <= 1'b0;
         primed <= 1'b0;
         cnt    <= '0;
         period <= '0;
      end else begin
         lrck_d <= lrck;
         if (rise) begin
            cnt    <= '0;
            period <= cnt_inc;
            primed <= 1'b1;
         end else begin
            if (cnt != CNT_MAX) cnt <= cnt_inc;
            if (timeout)        primed <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/i2s_ratio_controller.sv
// Qualifies the BCK/LRCK ratio over several frames, selects divider mode, sequences mute.
// Latency: outputs registered; a rise or timeout shows on the outputs one bck later.
// Backpressure: none; mute is held until the new mode has run MUTE_FRAMES clean frames.
module i2s_ratio_controller
   import i2s_pkg::*;
#(
   parameter int LOCK_COUNT  = 4,
   parameter int MUTE_FRAMES = 8,
   parameter int TIMEOUT     = 511,
   parameter int CNT_W       = 10
) (
   input  logic                   bck,
   input  logic                   rst_n,
   i2s_ratio_controller_if.master bus
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int FW = $clog2(MUTE_FRAMES + 1);

   logic [CNT_W-1:0] period;
   logic             meas_vld;
   mode_e            meas_cls;
   logic             timeout;

   state_e           state_q,   state_d;
   mode_e            cand_q,    cand_d;
   logic [MW-1:0]    match_q,   match_d;
   logic [FW-1:0]    fcnt_q,    fcnt_d;
   mode_e            mode_q,    mode_d;
   logic             locked_q,  locked_d;
   logic             mute_q,    mute_d;
   logic             div_rst_q, div_rst_d;

   i2s_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_meter (
      .bck      (bck),
      .rst_n    (rst_n),
      .lrck     (bus.lrck),
      .period   (period),
      .meas_vld (meas_vld),
      .meas_cls (meas_cls),
      .timeout  (timeout)
   );

   // State and registered outputs.
   always_ff @(posedge bck or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_UNLOCKED;
         cand_q    <= MODE_NONE;
         match_q   <= '0;
         fcnt_q    <= '0;
         mode_q    <= MODE_NONE;
         locked_q  <= 1'b0;
         mute_q    <= 1'b1;
         div_rst_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cand_q    <= cand_d;
         match_q   <= match_d;
         fcnt_q    <= fcnt_d;
         mode_q    <= mode_d;
         locked_q  <= locked_d;
         mute_q    <= mute_d;
         div_rst_q <= div_rst_d;
      end
   end

   // Next state per measured frame; timeout overrides everything.
   always_comb begin
      state_d   = state_q;
      cand_d    = cand_q;
      match_d   = match_q;
      fcnt_d    = fcnt_q;
      mode_d    = mode_q;
      div_rst_d = 1'b0;

      if (timeout) begin
         state_d = ST_UNLOCKED;
      end else if (meas_vld) begin
         case (state_q)
            ST_UNLOCKED: begin
               if (meas_cls != MODE_NONE) begin
                  cand_d  = meas_cls;
                  match_d = MW'(1);
                  state_d = ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (meas_cls == MODE_NONE) begin
                  state_d = ST_UNLOCKED;
               end else if (meas_cls == cand_q) begin
                  match_d = match_q + 1'b1;
                  if (match_d == MW'(LOCK_COUNT)) begin
                     mode_d    = cand_q;
                     div_rst_d = 1'b1;
                     fcnt_d    = '0;
                     state_d   = ST_MUTE_HOLD;
                  end
               end else begin
                  cand_d  = meas_cls;
                  match_d = MW'(1);
               end
            end
            ST_MUTE_HOLD: begin
               if (meas_cls == MODE_NONE) begin
                  state_d = ST_UNLOCKED;
               end else if (meas_cls == mode_q) begin
                  fcnt_d = fcnt_q + 1'b1;
                  if (fcnt_d == FW'(MUTE_FRAMES)) state_d = ST_LOCKED;
               end else begin
                  cand_d  = meas_cls;
                  match_d = MW'(1);
                  state_d = ST_ACQUIRE;
               end
            end
            ST_LOCKED: begin
               if (meas_cls == MODE_NONE) begin
                  state_d = ST_UNLOCKED;
               end else if (meas_cls != mode_q) begin
                  cand_d  = meas_cls;
                  match_d = MW'(1);
                  state_d = ST_ACQUIRE;
               end
            end
            default: state_d = ST_UNLOCKED;
         endcase
      end

      // Outputs follow the state being entered so they change together with it.
      if (state_d == ST_UNLOCKED || state_d == ST_ACQUIRE) mode_d = MODE_NONE;
      locked_d = (state_d == ST_MUTE_HOLD) || (state_d == ST_LOCKED);
      mute_d   = (state_d != ST_LOCKED);
   end

   assign bus.mode    = mode_q;
   assign bus.locked  = locked_q;
   assign bus.mute    = mute_q;
   assign bus.div_rst = div_rst_q;
   assign bus.period  = period;

endmodule

// File: tb/tb_i2s_ratio_controller.sv
// Self-checking bench: directed and random frame lengths against a run-length reference model.
// Latency: checks one bck after each lrck rise (#1 after the edge).
// Backpressure: none; the bench only drives lrck and reset.
module tb_i2s_ratio_controller;

   localparam int LOCK_COUNT  = 4;
   localparam int MUTE_FRAMES = 8;
   localparam int TIMEOUT     = 511;
   localparam int CNT_W       = 10;

   logic bck   = 1'b0;
   logic rst_n = 1'b0;

   i2s_ratio_controller_if #(.CNT_W(CNT_W)) bus();

   i2s_ratio_controller #(
      .LOCK_COUNT  (LOCK_COUNT),
      .MUTE_FRAMES (MUTE_FRAMES),
      .TIMEOUT     (TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .bck   (bck),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 bck = ~bck;

   int total = 0;
   int bad   = 0;

   // Reference model: the number of trailing identical valid measurements decides everything.
   int         m_run;
   logic [1:0] m_cls;
   bit         m_primed;
   int         m_prev_len;
   logic [1:0] m_mode;
   bit         m_locked, m_mute, m_div, m_per_ok;
   int         m_period;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] class_of(input int len);
      if (len == 64)  return 2'b00;
      if (len == 128) return 2'b01;
      if (len == 256) return 2'b10;
      return 2'b11;
   endfunction

   function void model_outputs();
      m_locked = (m_run >= LOCK_COUNT);
      m_mute   = (m_run < LOCK_COUNT + MUTE_FRAMES);
      m_mode   = m_locked ? m_cls : 2'b11;
   endfunction

   function void model_reset();
      m_run = 0; m_cls = 2'b11; m_primed = 0; m_div = 0;
      m_per_ok = 1; m_period = 0;
      model_outputs();
   endfunction

   function void model_timeout();
      m_run = 0; m_primed = 0; m_div = 0;
      model_outputs();
   endfunction

   function void model_rise(input int plen);
      logic [1:0] c;
      c     = class_of(plen);
      m_div = 0;
      if (!m_primed) begin
         m_primed = 1;
         m_per_ok = 0;
      end else begin
         m_per_ok = 1;
         m_period = plen;
         if (c == 2'b11)                   m_run = 0;
         else if (m_run > 0 && c == m_cls) m_run++;
         else begin m_cls = c; m_run = 1; end
         if (m_run == LOCK_COUNT) m_div = 1;
      end
      model_outputs();
   endfunction

   task automatic check_outputs(input string tag);
      check_eq({tag, ".mode"},    32'(bus.mode),    32'(m_mode));
      check_eq({tag, ".locked"},  32'(bus.locked),  32'(m_locked));
      check_eq({tag, ".mute"},    32'(bus.mute),    32'(m_mute));
      check_eq({tag, ".div_rst"}, 32'(bus.div_rst), 32'(m_div));
      if (m_per_ok) check_eq({tag, ".period"}, 32'(bus.period), 32'(m_period));
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, ".mode"},    32'(bus.mode),    32'd3);
      check_eq({tag, ".locked"},  32'(bus.locked),  32'd0);
      check_eq({tag, ".mute"},    32'(bus.mute),    32'd1);
      check_eq({tag, ".div_rst"}, 32'(bus.div_rst), 32'd0);
      check_eq({tag, ".period"},  32'(bus.period),  32'd0);
   endtask

   // One frame: lrck high for the first half; the rise is at the first edge.
   task automatic run_frame(input string tag, input int len);
      model_rise(m_prev_len);
      for (int i = 0; i < len; i++) begin
         bus.lrck = (i < len / 2);
         @(posedge bck); #1;
         if (i == 0)      check_outputs(tag);
         else if (i == 1) check_eq({tag, ".div_rst_drop"}, 32'(bus.div_rst), 32'd0);
      end
      m_prev_len = len;
   endtask

   task automatic run_frames(input string tag, input int len, input int n);
      for (int k = 0; k < n; k++) run_frame(tag, len);
   endtask

   // A rise followed by lrck stuck low long enough to time out.
   task automatic long_frame(input int len);
      model_rise(m_prev_len);
      for (int i = 0; i < len; i++) begin
         bus.lrck = (i < 32);
         @(posedge bck); #1;
         if (i == 0)           check_outputs("to_rise");
         if (i == TIMEOUT - 5) check_outputs("to_before");
         if (i == TIMEOUT + 1) model_timeout();
         if (i == TIMEOUT + 5) check_outputs("to_after");
      end
      m_prev_len = len;
   endtask

   int ratios[3] = '{64, 128, 256};
   int cur, pick, len;

   initial begin
      bus.lrck = 1'b0;
      model_reset();
      m_prev_len = 0;
      repeat (3) @(posedge bck);
      #1;
      check_reset_vals("rst");
      rst_n = 1'b1;
      @(posedge bck); #1;
      check_reset_vals("rst_rel");

      // Steady 128fs: lock on 5th rise, unmute on 13th.
      run_frames("f128", 128, 14);
      check_eq("f128_mode_end", 32'(bus.mode), 32'd1);
      check_eq("f128_mute_end", 32'(bus.mute), 32'd0);

      // 64fs lock then switch to 256fs.
      run_frames("f64", 64, 14);
      run_frames("f256", 256, 14);
      check_eq("f256_mode_end", 32'(bus.mode), 32'd2);

      // Alternating 128/64 never qualifies.
      for (int k = 0; k < 6; k++) begin
         run_frame("alt", 128);
         run_frame("alt", 64);
      end
      check_eq("alt_locked", 32'(bus.locked), 32'd0);

      // Lock at 64fs, stall lrck, then relock from a priming rise.
      run_frames("pre_to", 64, 14);
      long_frame(600);
      run_frames("post_to", 64, 6);
      check_eq("post_to_locked", 32'(bus.locked), 32'd1);

      // Bad frame during mute hold.
      run_frames("mh", 128, 7);
      run_frame("mh_bad", 100);
      run_frames("mh_after", 128, 3);

      // Randomised frame lengths.
      cur = 0;
      for (int f = 0; f < 200; f++) begin
         pick = $urandom_range(0, 99);
         if (pick < 6) cur = $urandom_range(0, 2);
         if (pick >= 94) len = $urandom_range(20, 300);
         else            len = ratios[cur];
         run_frame("rnd", len);
      end

      // Asynchronous reset while locked.
      run_frames("ar_pre", 64, 14);
      check_eq("ar_pre_locked", 32'(bus.locked), 32'd1);
      bus.lrck = 1'b1;
      @(posedge bck); #3;
      rst_n = 1'b0;
      #1;
      check_reset_vals("arst");
      model_reset();
      m_prev_len = 0;
      bus.lrck = 1'b0;
      #20;
      rst_n = 1'b1;
      #1;
      check_reset_vals("arst_rel");
      run_frames("ar_post", 64, 14);
      check_eq("ar_post_mute", 32'(bus.mute), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
